// File: rtl/fifo_read_arbiter.sv
// fifo_read_arbiter
//   Round-robin scheduler sharing the async FIFO read port between NREQ
//   consumers. Lives in the read clock domain in front of the read-pointer
//   handler. Each grant is a burst of up to BURST_MAX reads. No read is ever
//   issued while the FIFO is empty. A one-cycle-delayed valid strobe is
//   steered to the consumer that owned the read.
//
// Ports
//   rd_clk    read-domain clock, rising edge
//   rd_rst_n  asynchronous active-low reset
//   req       per-consumer request level, held until its burst is done
//   req_len   per-consumer burst length, consumer i at [i*CNTW +: CNTW]
//   rempty    FIFO empty flag from the read-pointer handler
//   rd_en     read strobe to the read-pointer handler
//   gnt       one-hot grant to the current owner
//   rvalid    rvalid[i]=1: read data on the bus belongs to consumer i
//   busy      high whenever the arbiter is not idle
//   done      one-cycle pulse when a burst completes normally
`timescale 1ns/1ps
module fifo_read_arbiter #(
  parameter int NREQ      = 4,
  parameter int CNTW      = 4,
  parameter int BURST_MAX = 8
) (
  input  logic                 rd_clk,
  input  logic                 rd_rst_n,
  input  logic [NREQ-1:0]      req,
  input  logic [NREQ*CNTW-1:0] req_len,
  input  logic                 rempty,
  output logic                 rd_en,
  output logic [NREQ-1:0]      gnt,
  output logic [NREQ-1:0]      rvalid,
  output logic                 busy,
  output logic                 done
);

  localparam int OW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {
    IDLE,
    GRANT,
    BURST,
    DONE
  } state_t;

  state_t          state;
  state_t          state_next;
  logic [OW-1:0]   owner;
  logic [OW-1:0]   rr_ptr;
  logic [CNTW-1:0] cnt;

  logic [CNTW-1:0] len_arr [NREQ];
  logic            win_found;
  logic [OW-1:0]   win;
  logic [OW-1:0]   scan_w;
  int unsigned     scan_idx;
  logic [CNTW-1:0] win_len;
  logic [CNTW-1:0] win_len_clamped;
  logic [OW-1:0]   rr_next;

  // Unpack the flat length bus so the winner can index it directly.
  always_comb begin
    for (int unsigned i = 0; i < NREQ; i++) begin
      len_arr[i] = req_len[i*CNTW +: CNTW];
    end
  end

  // Round-robin search: first set request starting at rr_ptr, wrapping.
  always_comb begin
    win_found = 1'b0;
    win       = '0;
    scan_idx  = 0;
    scan_w    = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      scan_idx = int'(rr_ptr) + i;
      if (scan_idx >= NREQ) begin
        scan_idx = scan_idx - NREQ;
      end
      scan_w = OW'(scan_idx);
      if (!win_found && req[scan_w]) begin
        win_found = 1'b1;
        win       = scan_w;
      end
    end
  end

  // Zero-length requests still get one read; long ones are capped.
  always_comb begin
    win_len = len_arr[win];
    if (win_len == '0) begin
      win_len_clamped = CNTW'(1);
    end else if (win_len > CNTW'(BURST_MAX)) begin
      win_len_clamped = CNTW'(BURST_MAX);
    end else begin
      win_len_clamped = win_len;
    end
  end

  assign rr_next = (win == OW'(NREQ - 1)) ? '0 : win + OW'(1);

  // State register
  always_ff @(posedge rd_clk or negedge rd_rst_n) begin
    if (!rd_rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic; an owner dropping its request beats completion.
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:  if (win_found) state_next = GRANT;
      GRANT: state_next = BURST;
      BURST: begin
        if (!req[owner]) begin
          state_next = IDLE;
        end else if (rd_en && (cnt == CNTW'(1))) begin
          state_next = DONE;
        end
      end
      DONE:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Output logic; all outputs decode from the state so reset clears them at once.
  always_comb begin
    gnt   = '0;
    rd_en = 1'b0;
    busy  = (state != IDLE);
    done  = (state == DONE);
    if ((state == GRANT) || (state == BURST)) begin
      gnt[owner] = 1'b1;
    end
    if (state == BURST) begin
      rd_en = !rempty && req[owner];
    end
  end

  // Arbitration datapath: owner, burst counter, round-robin pointer.
  always_ff @(posedge rd_clk or negedge rd_rst_n) begin
    if (!rd_rst_n) begin
      owner  <= '0;
      rr_ptr <= '0;
      cnt    <= '0;
    end else begin
      if ((state == IDLE) && win_found) begin
        owner  <= win;
        cnt    <= win_len_clamped;
        rr_ptr <= rr_next;
      end else if (rd_en) begin
        cnt <= cnt - CNTW'(1);
      end
    end
  end

  // Data-valid follows the read strobe by one cycle to match FIFO memory latency.
  always_ff @(posedge rd_clk or negedge rd_rst_n) begin
    if (!rd_rst_n) begin
      rvalid <= '0;
    end else begin
      rvalid <= '0;
      if (rd_en) begin
        rvalid[owner] <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_fifo_read_arbiter.sv
`timescale 1ns/1ps
module tb_fifo_read_arbiter;

  localparam int NREQ      = 4;
  localparam int CNTW      = 4;
  localparam int BURST_MAX = 8;

  logic                 rd_clk = 1'b0;
  logic                 rd_rst_n = 1'b0;
  logic [NREQ-1:0]      req = '0;
  logic [NREQ*CNTW-1:0] req_len = '0;
  logic                 rempty = 1'b0;
  logic                 rd_en;
  logic [NREQ-1:0]      gnt;
  logic [NREQ-1:0]      rvalid;
  logic                 busy;
  logic                 done;

  int n_cmp = 0;
  int n_bad = 0;

  fifo_read_arbiter #(.NREQ(NREQ), .CNTW(CNTW), .BURST_MAX(BURST_MAX)) dut (
    .rd_clk  (rd_clk),
    .rd_rst_n(rd_rst_n),
    .req     (req),
    .req_len (req_len),
    .rempty  (rempty),
    .rd_en   (rd_en),
    .gnt     (gnt),
    .rvalid  (rvalid),
    .busy    (busy),
    .done    (done)
  );

  always #5 rd_clk = ~rd_clk;

  function automatic logic [NREQ-1:0] oh(int w);
    return NREQ'(1) << w;
  endfunction

  function automatic int clamp_len(int l);
    if (l == 0) return 1;
    if (l > BURST_MAX) return BURST_MAX;
    return l;
  endfunction

  task automatic do_reset();
    rd_rst_n = 1'b0;
    req      = '0;
    req_len  = '0;
    rempty   = 1'b0;
    repeat (2) @(negedge rd_clk);
    rd_rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    n_cmp++; if (gnt !== '0)    begin n_bad++; $display("FAIL reset_gnt got %b want 0", gnt); end
    n_cmp++; if (rd_en !== 1'b0) begin n_bad++; $display("FAIL reset_rd_en got %b want 0", rd_en); end
    n_cmp++; if (rvalid !== '0) begin n_bad++; $display("FAIL reset_rvalid got %b want 0", rvalid); end
    n_cmp++; if (busy !== 1'b0)  begin n_bad++; $display("FAIL reset_busy got %b want 0", busy); end
    n_cmp++; if (done !== 1'b0)  begin n_bad++; $display("FAIL reset_done got %b want 0", done); end
  endtask

  // Single consumer, length 3, checked cycle by cycle against the expected timeline.
  task automatic test_single();
    logic [NREQ-1:0] eg, ev;
    logic er, ed, eb;
    do_reset();
    req     = 4'b0001;
    req_len = 16'h0003;
    for (int c = 0; c <= 6; c++) begin
      #1;
      eg = (c >= 1 && c <= 4) ? 4'b0001 : 4'b0000;
      er = (c >= 2 && c <= 4);
      ev = (c >= 3 && c <= 5) ? 4'b0001 : 4'b0000;
      ed = (c == 5);
      eb = (c >= 1 && c <= 5);
      n_cmp++; if (gnt !== eg)    begin n_bad++; $display("FAIL single_gnt c=%0d got %b want %b", c, gnt, eg); end
      n_cmp++; if (rd_en !== er)  begin n_bad++; $display("FAIL single_rd_en c=%0d got %b want %b", c, rd_en, er); end
      n_cmp++; if (rvalid !== ev) begin n_bad++; $display("FAIL single_rvalid c=%0d got %b want %b", c, rvalid, ev); end
      n_cmp++; if (done !== ed)   begin n_bad++; $display("FAIL single_done c=%0d got %b want %b", c, done, ed); end
      n_cmp++; if (busy !== eb)   begin n_bad++; $display("FAIL single_busy c=%0d got %b want %b", c, busy, eb); end
      @(negedge rd_clk);
    end
  endtask

  // All consumers requesting with length 1: strict rotation, one read per grant.
  task automatic test_rotation();
    int exp_order [5] = '{0, 1, 2, 3, 0};
    int order [5];
    int ng, rdc, idx;
    logic [NREQ-1:0] prev_g;
    do_reset();
    req     = 4'b1111;
    req_len = 16'h1111;
    ng = 0; rdc = 0; prev_g = '0;
    for (int c = 0; c < 22; c++) begin
      #1;
      n_cmp++; if ((gnt & (gnt - 1'b1)) !== '0) begin n_bad++; $display("FAIL rot_onehot c=%0d got %b want onehot_or_zero", c, gnt); end
      if (gnt !== '0 && prev_g === '0 && ng < 5) begin
        idx = -1;
        for (int k = 0; k < NREQ; k++) if (gnt === oh(k)) idx = k;
        order[ng] = idx;
        ng++;
      end
      if (rd_en) rdc++;
      if (done) begin
        n_cmp++; if (rdc !== 1) begin n_bad++; $display("FAIL rot_reads_per_grant got %0d want 1", rdc); end
        rdc = 0;
      end
      prev_g = gnt;
      @(negedge rd_clk);
    end
    n_cmp++; if (ng !== 5) begin n_bad++; $display("FAIL rot_grant_count got %0d want 5", ng); end
    for (int k = 0; k < 5; k++) begin
      if (k < ng) begin
        n_cmp++; if (order[k] !== exp_order[k]) begin n_bad++; $display("FAIL rot_order[%0d] got %0d want %0d", k, order[k], exp_order[k]); end
      end
    end
  endtask

  // Empty FIFO for 4 cycles after the 2nd read: burst stalls and resumes.
  task automatic test_stall();
    int reads, rv, stall;
    bit stall_started, seen_done;
    do_reset();
    req     = 4'b0100;
    req_len = 16'h0400;
    reads = 0; rv = 0; stall = 0; stall_started = 0; seen_done = 0;
    for (int c = 0; c < 40 && !seen_done; c++) begin
      #1;
      n_cmp++; if (rd_en && rempty) begin n_bad++; $display("FAIL stall_underflow c=%0d got rd_en=1 want 0", c); end
      if (stall > 0) begin
        n_cmp++; if (rd_en !== 1'b0) begin n_bad++; $display("FAIL stall_rd_en c=%0d got %b want 0", c, rd_en); end
        n_cmp++; if (dut.cnt !== 4'd2) begin n_bad++; $display("FAIL stall_cnt c=%0d got %0d want 2", c, dut.cnt); end
      end
      if (rd_en) reads++;
      if (rvalid[2]) rv++;
      if (done) seen_done = 1;
      if (!seen_done) begin
        @(negedge rd_clk);
        if (!stall_started && reads == 2) begin
          rempty = 1'b1; stall = 4; stall_started = 1;
        end else if (stall > 0) begin
          stall--;
          if (stall == 0) rempty = 1'b0;
        end
      end
    end
    n_cmp++; if (!seen_done) begin n_bad++; $display("FAIL stall_done got 0 want 1"); end
    n_cmp++; if (reads !== 4) begin n_bad++; $display("FAIL stall_reads got %0d want 4", reads); end
    n_cmp++; if (rv !== 4)    begin n_bad++; $display("FAIL stall_rvalid got %0d want 4", rv); end
  endtask

  // Length clamping: 0 reads once, above BURST_MAX reads BURST_MAX times.
  task automatic test_len_clamp();
    int lens [2] = '{0, 15};
    int reads, rv;
    bit seen_done;
    for (int t = 0; t < 2; t++) begin
      do_reset();
      req     = 4'b0010;
      req_len = 16'(lens[t]) << CNTW;
      reads = 0; rv = 0; seen_done = 0;
      for (int c = 0; c < 40 && !seen_done; c++) begin
        #1;
        if (rd_en) reads++;
        if (rvalid[1]) rv++;
        if (done) seen_done = 1;
        else @(negedge rd_clk);
      end
      n_cmp++; if (!seen_done) begin n_bad++; $display("FAIL clamp_done len=%0d got 0 want 1", lens[t]); end
      n_cmp++; if (reads !== clamp_len(lens[t])) begin n_bad++; $display("FAIL clamp_reads len=%0d got %0d want %0d", lens[t], reads, clamp_len(lens[t])); end
      n_cmp++; if (rv !== clamp_len(lens[t])) begin n_bad++; $display("FAIL clamp_rvalid len=%0d got %0d want %0d", lens[t], rv, clamp_len(lens[t])); end
    end
  endtask

  // Owner 3 drops its request after 2 reads: abort, no done, pointer wrapped to 0.
  task automatic test_abort();
    int reads, phase;
    do_reset();
    req     = 4'b1000;
    req_len = 16'h6000;
    reads = 0; phase = 0;
    for (int c = 0; c < 40 && phase < 4; c++) begin
      #1;
      n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL abort_no_done c=%0d got %b want 0", c, done); end
      case (phase)
        1: begin
          n_cmp++; if (rd_en !== 1'b0)     begin n_bad++; $display("FAIL abort_rd_en got %b want 0", rd_en); end
          n_cmp++; if (busy !== 1'b1)      begin n_bad++; $display("FAIL abort_busy got %b want 1", busy); end
          n_cmp++; if (rvalid !== 4'b1000) begin n_bad++; $display("FAIL abort_rvalid got %b want 1000", rvalid); end
        end
        2: begin
          n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL abort_idle_busy got %b want 0", busy); end
          n_cmp++; if (gnt !== '0)    begin n_bad++; $display("FAIL abort_idle_gnt got %b want 0", gnt); end
        end
        3: begin
          n_cmp++; if (gnt !== 4'b0010) begin n_bad++; $display("FAIL abort_next_gnt got %b want 0010", gnt); end
        end
        default: ;
      endcase
      if (phase > 0) phase++;
      if (rd_en) reads++;
      @(negedge rd_clk);
      if (phase == 0 && reads == 2) begin
        req   = 4'b0110;
        phase = 1;
      end
    end
    n_cmp++; if (phase !== 4) begin n_bad++; $display("FAIL abort_timeout got phase %0d want 4", phase); end
  endtask

  // Reset asserted between edges mid-burst: outputs clear at once; pointer restarts at 0.
  task automatic test_async_reset();
    int reads;
    bit got;
    do_reset();
    req     = 4'b0100;
    req_len = 16'h0800;
    reads = 0;
    for (int c = 0; c < 20 && reads < 2; c++) begin
      #1;
      if (rd_en) reads++;
      @(negedge rd_clk);
    end
    n_cmp++; if (reads !== 2) begin n_bad++; $display("FAIL areset_setup got %0d want 2", reads); end
    #2 rd_rst_n = 1'b0;
    #1;
    n_cmp++; if (gnt !== '0)    begin n_bad++; $display("FAIL areset_gnt got %b want 0", gnt); end
    n_cmp++; if (rd_en !== 1'b0) begin n_bad++; $display("FAIL areset_rd_en got %b want 0", rd_en); end
    n_cmp++; if (rvalid !== '0) begin n_bad++; $display("FAIL areset_rvalid got %b want 0", rvalid); end
    n_cmp++; if (busy !== 1'b0)  begin n_bad++; $display("FAIL areset_busy got %b want 0", busy); end
    n_cmp++; if (done !== 1'b0)  begin n_bad++; $display("FAIL areset_done got %b want 0", done); end
    req = 4'b1010;
    repeat (2) @(negedge rd_clk);
    rd_rst_n = 1'b1;
    got = 0;
    for (int c = 0; c < 10 && !got; c++) begin
      #1;
      if (gnt !== '0) begin
        got = 1;
        n_cmp++; if (gnt !== 4'b0010) begin n_bad++; $display("FAIL areset_first_gnt got %b want 0010", gnt); end
      end
      @(negedge rd_clk);
    end
    n_cmp++; if (!got) begin n_bad++; $display("FAIL areset_grant_timeout got none want 0010"); end
  endtask

  // Random requests, lengths and empty flag against a rule-level reference model.
  task automatic test_random();
    int model_rr, cur_owner, prev_owner, exp_reads, reads, w, idx;
    bit in_grant, first, was_idle, prev_rd, exp_done, exp_grant, exp_rd, exp_busy, drop_pend;
    logic [NREQ-1:0] prev_req, exp_rv;
    logic [NREQ*CNTW-1:0] prev_len;
    do_reset();
    model_rr = 0; cur_owner = 0; prev_owner = 0; exp_reads = 0; reads = 0;
    in_grant = 0; was_idle = 1; prev_rd = 0; drop_pend = 0;
    prev_req = '0; prev_len = '0;
    for (int c = 0; c < 3000; c++) begin
      if (drop_pend) begin
        req = req & ~oh(cur_owner);
        drop_pend = 0;
      end
      for (int i = 0; i < NREQ; i++) begin
        if (((req >> i) & 1) == 0 && $urandom_range(0, 3) == 0) begin
          req     = req | oh(i);
          req_len = (req_len & ~(16'hF << (i * CNTW))) | (16'($urandom_range(0, 15)) << (i * CNTW));
        end
      end
      rempty = ($urandom_range(0, 3) == 0);
      #1;
      first    = 0;
      exp_rv   = prev_rd ? oh(prev_owner) : '0;
      exp_done = in_grant && prev_rd && (reads == exp_reads);
      exp_grant = was_idle && (prev_req != '0);
      n_cmp++; if (rvalid !== exp_rv) begin n_bad++; $display("FAIL rand_rvalid c=%0d got %b want %b", c, rvalid, exp_rv); end
      n_cmp++; if (done !== exp_done) begin n_bad++; $display("FAIL rand_done c=%0d got %b want %b", c, done, exp_done); end
      if (exp_done) begin
        in_grant  = 0;
        drop_pend = 1;
        n_cmp++; if (gnt !== '0) begin n_bad++; $display("FAIL rand_done_gnt c=%0d got %b want 0", c, gnt); end
      end else if (exp_grant) begin
        w = -1;
        for (int k = 0; k < NREQ; k++) begin
          idx = (model_rr + k) % NREQ;
          if (w < 0 && ((prev_req >> idx) & 1) != 0) w = idx;
        end
        n_cmp++; if (gnt !== oh(w)) begin n_bad++; $display("FAIL rand_winner c=%0d got %b want %b", c, gnt, oh(w)); end
        cur_owner = w;
        model_rr  = (w + 1) % NREQ;
        exp_reads = clamp_len(int'((prev_len >> (w * CNTW)) & 16'hF));
        reads     = 0;
        in_grant  = 1;
        first     = 1;
      end else if (in_grant) begin
        n_cmp++; if (gnt !== oh(cur_owner)) begin n_bad++; $display("FAIL rand_gnt c=%0d got %b want %b", c, gnt, oh(cur_owner)); end
      end else begin
        n_cmp++; if (gnt !== '0) begin n_bad++; $display("FAIL rand_idle_gnt c=%0d got %b want 0", c, gnt); end
      end
      exp_rd   = in_grant && !first && !rempty && (((req >> cur_owner) & 1) != 0);
      exp_busy = in_grant || exp_done;
      n_cmp++; if (rd_en !== exp_rd)  begin n_bad++; $display("FAIL rand_rd_en c=%0d got %b want %b", c, rd_en, exp_rd); end
      n_cmp++; if (busy !== exp_busy) begin n_bad++; $display("FAIL rand_busy c=%0d got %b want %b", c, busy, exp_busy); end
      if (exp_rd) reads++;
      prev_rd    = exp_rd;
      prev_owner = cur_owner;
      was_idle   = !in_grant && !exp_done;
      prev_req   = req;
      prev_len   = req_len;
      @(negedge rd_clk);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_single();
    test_rotation();
    test_stall();
    test_len_clamp();
    test_abort();
    test_async_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
